// File: rtl/bus_arbiter_if.sv
// Arbiter <-> initiator/target signal bundle for the serial bus.
// Latency: none (wires only).
// Backpressure: none; initiators hold req until granted, the target paces with ack/split pulses.
//
// Modports:
//   master : the arbiter (drives grant, owner, bus_busy, init_ack, init_split_ack, timeout_err)
//   slave  : initiators + target side (drives req, tgt_ack, tgt_split_ack, tgt_split_rdy)
interface bus_arbiter_if #(
  parameter int NUM_INIT = 2
) ();
  localparam int OWNER_W = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;

  logic [NUM_INIT-1:0] req;
  logic [NUM_INIT-1:0] grant;
  logic [OWNER_W-1:0]  owner;
  logic                bus_busy;
  logic                tgt_ack;
  logic                tgt_split_ack;
  logic                tgt_split_rdy;
  logic [NUM_INIT-1:0] init_ack;
  logic [NUM_INIT-1:0] init_split_ack;
  logic                timeout_err;

  modport master (
    input  req, tgt_ack, tgt_split_ack, tgt_split_rdy,
    output grant, owner, bus_busy, init_ack, init_split_ack, timeout_err
  );

  modport slave (
    output req, tgt_ack, tgt_split_ack, tgt_split_rdy,
    input  grant, owner, bus_busy, init_ack, init_split_ack, timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one target path between NUM_INIT initiators, with one parked split owner.
// Latency: req -> grant 1 cycle; release 1 cycle after tgt_ack; init_ack/init_split_ack combinational.
// Backpressure: no preemption; a pending split resume waits until the current owner releases the bus.
//
// Ports: clk, rst_n (async active-low), bus (bus_arbiter_if.master: req/grant/owner/bus_busy,
//        tgt_ack/tgt_split_ack/tgt_split_rdy, init_ack/init_split_ack, timeout_err).
// Optional: define ARB_TIMEOUT_EN to enable the forced-release watchdog (TIMEOUT_CYCLES);
//           otherwise grant is held indefinitely and timeout_err is tied 0.
module bus_arbiter #(
  parameter int NUM_INIT = 2
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input logic           clk,
  input logic           rst_n,
  bus_arbiter_if.master bus
);
  localparam int OWNER_W = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;

  typedef logic [NUM_INIT-1:0] vec_t;
  typedef logic [OWNER_W-1:0]  idx_t;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SPLIT_WAIT, S_RESUME} state_t;

  function automatic vec_t onehot(idx_t i);
    vec_t v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic idx_t next_idx(idx_t i);
    return (int'(i) == NUM_INIT - 1) ? '0 : i + idx_t'(1);
  endfunction

  state_t state, state_n;
  vec_t   grant_q, grant_n;
  idx_t   owner_q, owner_n;
  idx_t   rr_ptr, rr_ptr_n;
  idx_t   split_owner, split_owner_n;
  logic   split_valid, split_valid_n;

  vec_t   parked, eligible;
  idx_t   winner, cand;
  logic   found;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             tmo_q, tmo_n;
`endif

  // A parked split owner is excluded from normal arbitration until its resume completes.
  assign parked   = split_valid ? onehot(split_owner) : '0;
  assign eligible = bus.req & ~parked;

  // First eligible initiator at or after rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_INIT; i++) begin
      cand = idx_t'((int'(rr_ptr) + i) % NUM_INIT);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr      <= '0;
      split_owner <= '0;
      split_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt         <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      grant_q     <= grant_n;
      owner_q     <= owner_n;
      rr_ptr      <= rr_ptr_n;
      split_owner <= split_owner_n;
      split_valid <= split_valid_n;
`ifdef ARB_TIMEOUT_EN
      cnt         <= cnt_n;
      tmo_q       <= tmo_n;
`endif
    end
  end

  always_comb begin
    state_n       = state;
    grant_n       = grant_q;
    owner_n       = owner_q;
    rr_ptr_n      = rr_ptr;
    split_owner_n = split_owner;
    split_valid_n = split_valid;

    unique case (state)
      S_IDLE: begin
        // A ready split response beats fresh requests.
        if (bus.tgt_split_rdy && split_valid) begin
          grant_n = onehot(split_owner);
          owner_n = split_owner;
          state_n = S_RESUME;
        end else if (found) begin
          grant_n = onehot(winner);
          owner_n = winner;
          state_n = S_GRANT;
        end
      end
      S_GRANT: begin
        // tgt_ack wins over a simultaneous split_ack; a second split while one is parked is ignored.
        if (bus.tgt_ack) begin
          grant_n  = '0;
          rr_ptr_n = next_idx(owner_q);
          state_n  = S_IDLE;
        end else if (bus.tgt_split_ack && !split_valid) begin
          split_owner_n = owner_q;
          split_valid_n = 1'b1;
          grant_n       = '0;
          rr_ptr_n      = next_idx(owner_q);
          state_n       = S_SPLIT_WAIT;
        end else if (!bus.req[owner_q]) begin
          grant_n  = '0;
          rr_ptr_n = next_idx(owner_q);
          state_n  = S_IDLE;
        end
      end
      S_SPLIT_WAIT: state_n = S_IDLE;
      S_RESUME: begin
        if (bus.tgt_ack) begin
          split_valid_n = 1'b0;
          grant_n       = '0;
          state_n       = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

`ifdef ARB_TIMEOUT_EN
    // Counts granted cycles while no transition is already underway; restarts on every state entry.
    tmo_n = 1'b0;
    cnt_n = '0;
    if ((state == S_GRANT || state == S_RESUME) && state_n == state) begin
      if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        grant_n  = '0;
        rr_ptr_n = next_idx(owner_q);
        tmo_n    = 1'b1;
        state_n  = S_IDLE;
        if (state == S_RESUME) split_valid_n = 1'b0;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
`endif
  end

  assign bus.grant          = grant_q;
  assign bus.owner          = owner_q;
  assign bus.bus_busy       = |grant_q;
  // grant is already the owner's one-hot, and zero when the bus is idle.
  assign bus.init_ack       = bus.tgt_ack ? grant_q : '0;
  assign bus.init_split_ack = (state == S_GRANT && bus.tgt_split_ack && !bus.tgt_ack && !split_valid)
                              ? grant_q : '0;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_err    = tmo_q;
`else
  assign bus.timeout_err    = 1'b0;
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (NUM_INIT=2): each vector drives inputs for one cycle
// and pushes the outputs expected during that cycle; a monitor pops and compares them.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_INIT(2)) bus ();

  bus_arbiter #(
    .NUM_INIT(2)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [1:0] grant;
    logic       owner;
    logic [1:0] iack;
    logic [1:0] isack;
    logic       tmo;
  } exp_t;

  exp_t       sb[$];
  exp_t       got;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [1:0] prev_grant = 2'b00;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic vec(input string tag, input logic [1:0] req, input logic ack, input logic sack,
                     input logic rdy, input logic [1:0] g, input logic o, input logic [1:0] ia,
                     input logic [1:0] isa, input logic tmo);
    exp_t e;
    @(negedge clk);
    bus.req           = req;
    bus.tgt_ack       = ack;
    bus.tgt_split_ack = sack;
    bus.tgt_split_rdy = rdy;
    e.tag   = tag;
    e.grant = g;
    e.owner = o;
    e.iack  = ia;
    e.isack = isa;
    e.tmo   = tmo;
    sb.push_back(e);
  endtask

  // Monitor: invariants every cycle, scoreboard entry when one is pending.
  always @(negedge clk) begin
    #2;
    check_eq("onehot0", 32'($onehot0(bus.grant)), 32'd1);
    check_eq("handover_gap",
             32'(prev_grant != 2'b00 && bus.grant != 2'b00 && bus.grant != prev_grant), 32'd0);
    prev_grant = bus.grant;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check_eq({got.tag, ".grant"}, 32'(bus.grant),          32'(got.grant));
      check_eq({got.tag, ".owner"}, 32'(bus.owner),          32'(got.owner));
      check_eq({got.tag, ".busy"},  32'(bus.bus_busy),       32'(got.grant != 2'b00));
      check_eq({got.tag, ".iack"},  32'(bus.init_ack),       32'(got.iack));
      check_eq({got.tag, ".isack"}, 32'(bus.init_split_ack), 32'(got.isack));
      check_eq({got.tag, ".tmo"},   32'(bus.timeout_err),    32'(got.tmo));
    end
  end

  initial begin
    rst_n             = 1'b1;
    bus.req           = 2'b00;
    bus.tgt_ack       = 1'b0;
    bus.tgt_split_ack = 1'b0;
    bus.tgt_split_rdy = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check_eq("rst.grant", 32'(bus.grant),       32'd0);
    check_eq("rst.owner", 32'(bus.owner),       32'd0);
    check_eq("rst.busy",  32'(bus.bus_busy),    32'd0);
    check_eq("rst.tmo",   32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, 1-cycle latency, ack routing.
    vec("t1_req",   2'b01, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    vec("t1_grant", 2'b01, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    vec("t1_ack",   2'b01, 1, 0, 0, 2'b01, 0, 2'b01, 2'b00, 0);
    vec("t1_rel",   2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);

    // Round-robin with an idle cycle between owners (rr_ptr is 1 after t1).
    vec("t2_a0", 2'b11, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    for (int k = 0; k < 3; k++)
      vec($sformatf("t2_a%0d", k + 1), 2'b11, 0, 0, 0, 2'b10, 1, 2'b00, 2'b00, 0);
    vec("t2_a4", 2'b11, 1, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0);
    vec("t2_b0", 2'b11, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0);
    for (int k = 0; k < 3; k++)
      vec($sformatf("t2_b%0d", k + 1), 2'b11, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    vec("t2_b4", 2'b11, 1, 0, 0, 2'b01, 0, 2'b01, 2'b00, 0);
    vec("t2_c0", 2'b11, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    vec("t2_c1", 2'b11, 1, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0);
    vec("t2_c2", 2'b00, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0);

    // Split: Init0 parked, Init1 gets the bus.
    vec("t3_req",   2'b01, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0);
    vec("t3_grant", 2'b01, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    vec("t3_split", 2'b01, 0, 1, 0, 2'b01, 0, 2'b00, 2'b01, 0);
    vec("t3_wait",  2'b11, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    vec("t3_idle",  2'b11, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    vec("t3_i1",    2'b11, 0, 0, 0, 2'b10, 1, 2'b00, 2'b00, 0);

    // Split-ready while Init1 owns the bus: no preemption, then resume without req[0].
    vec("t5_rdy0", 2'b11, 0, 0, 1, 2'b10, 1, 2'b00, 2'b00, 0);
    vec("t5_rdy1", 2'b11, 0, 0, 1, 2'b10, 1, 2'b00, 2'b00, 0);
    vec("t5_ack",  2'b11, 1, 0, 1, 2'b10, 1, 2'b10, 2'b00, 0);
    vec("t5_gap",  2'b10, 0, 0, 1, 2'b00, 1, 2'b00, 2'b00, 0);
    vec("t4_res",  2'b10, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 0);
    vec("t4_ack",  2'b10, 1, 0, 1, 2'b01, 0, 2'b01, 2'b00, 0);
    vec("t4_clr",  2'b10, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    vec("t4_i1",   2'b10, 0, 0, 0, 2'b10, 1, 2'b00, 2'b00, 0);

    // Abandoned request releases the bus; Init0 is no longer parked.
    vec("abn_drop", 2'b00, 0, 0, 0, 2'b10, 1, 2'b00, 2'b00, 0);
    vec("abn_rel",  2'b00, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0);
    vec("t4_p0",    2'b01, 0, 0, 1, 2'b00, 1, 2'b00, 2'b00, 0);
    vec("t4_p1",    2'b01, 1, 0, 0, 2'b01, 0, 2'b01, 2'b00, 0);
    vec("t4_p2",    2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);

    // tgt_ack and tgt_split_ack together: ack wins, nothing parked.
    vec("both0", 2'b01, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    vec("both1", 2'b01, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    vec("both2", 2'b01, 1, 1, 0, 2'b01, 0, 2'b01, 2'b00, 0);
    vec("both3", 2'b01, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    vec("both4", 2'b01, 1, 0, 0, 2'b01, 0, 2'b01, 2'b00, 0);
    vec("both5", 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);

    // Long hold with no ack.
    vec("t6_req", 2'b01, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++)
      vec($sformatf("t6_hold%0d", k), 2'b01, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    vec("t6_drop", 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1);
    vec("t6_end",  2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
`else
    for (int k = 0; k < 12; k++)
      vec($sformatf("t6_hold%0d", k), 2'b01, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    vec("t6_ack", 2'b01, 1, 0, 0, 2'b01, 0, 2'b01, 2'b00, 0);
    vec("t6_end", 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
`endif

    // Reset mid-transaction with a split parked: everything cleared, split dropped.
    vec("r1", 2'b01, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    vec("r2", 2'b01, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    vec("r3", 2'b01, 0, 1, 0, 2'b01, 0, 2'b00, 2'b01, 0);
    vec("r4", 2'b10, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    vec("r5", 2'b10, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    vec("r6", 2'b10, 0, 0, 0, 2'b10, 1, 2'b00, 2'b00, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst.grant", 32'(bus.grant),    32'd0);
    check_eq("mid_rst.owner", 32'(bus.owner),    32'd0);
    check_eq("mid_rst.busy",  32'(bus.bus_busy), 32'd0);
    bus.req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    vec("r7", 2'b00, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0);
    vec("r8", 2'b00, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0);

    @(negedge clk);
    #3;
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
